// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition threshold detector: FSM encodings and counter widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package acq_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } acq_state_e;

    // Hit/miss counters hold up to 15, the dwell counter up to 255.
    localparam int HIT_CW   = 4;
    localparam int MISS_CW  = 4;
    localparam int DWELL_CW = 8;

endpackage

// File: rtl/acq_mag_est.sv
// Magnitude estimator: integmag = max(|a|,|b|) + min(|a|,|b|)/2, exact, no saturation.
// Latency: absolutes at t+1, magnitude and valid at t+2.
// Backpressure: none; fully pipelined, accepts a new sample every cycle.
module acq_mag_est #(
    parameter int W = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vld_i,
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic [W:0]          mag_o,
    output logic                mag_vld_o
);

    logic [W-1:0] a_u, b_u;
    logic [W-1:0] abs_a_d, abs_b_d;
    logic [W-1:0] abs_a_q, abs_b_q;
    logic         vld1_q;
    logic [W-1:0] max_v, min_v;
    logic [W:0]   mag_d;
    logic [W:0]   mag_q;
    logic         mag_vld_q;

    // Absolute values as W-bit unsigned; the most negative input maps to 2^(W-1) without wrapping.
    always_comb begin
        a_u     = a_i;
        b_u     = b_i;
        abs_a_d = a_u[W-1] ? (~a_u + W'(1)) : a_u;
        abs_b_d = b_u[W-1] ? (~b_u + W'(1)) : b_u;
    end

    // Stage 1: register the absolutes and their valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abs_a_q <= '0;
            abs_b_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q <= vld_i;
            if (vld_i) begin
                abs_a_q <= abs_a_d;
                abs_b_q <= abs_b_d;
            end
        end
    end

    // Order the absolutes and form max + min/2 in W+1 bits.
    always_comb begin
        if (abs_a_q >= abs_b_q) begin
            max_v = abs_a_q;
            min_v = abs_b_q;
        end else begin
            max_v = abs_b_q;
            min_v = abs_a_q;
        end
        mag_d = {1'b0, max_v} + {2'b00, min_v[W-1:1]};
    end

    // Stage 2: register the magnitude; it holds its value between valid samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q     <= '0;
            mag_vld_q <= 1'b0;
        end else begin
            mag_vld_q <= vld1_q;
            if (vld1_q) begin
                mag_q <= mag_d;
            end
        end
    end

    assign mag_o     = mag_q;
    assign mag_vld_o = mag_vld_q;

endmodule

// File: rtl/acq_threshold_detector.sv
// Acquisition threshold detector: magnitude estimate, hit/miss test and SEARCH/CONFIRM/LOCKED FSM.
// Latency: integmag/mag_vld at t+2, acq/acq_lock/dwell_to at t+3; ACQ_HYST_EN selects thresh_lo for loss.
// Backpressure: none; aen may be asserted every cycle.
module acq_threshold_detector
    import acq_pkg::*;
#(
    parameter int W       = 20,
    parameter int TW      = 15,
    parameter int HIT_N   = 4,
    parameter int MISS_N  = 4,
    parameter int DWELL_N = 8
) (
    input  logic                mclk,
    input  logic                res,
    input  logic                aen,
    input  logic signed [W-1:0] ain,
    input  logic signed [W-1:0] bin,
    input  logic [TW-1:0]       thresh,
    input  logic [TW-1:0]       thresh_lo,
    output logic [W:0]          integmag,
    output logic                mag_vld,
    output logic                acq,
    output logic                acq_lock,
    output logic                dwell_to
);

    localparam logic [HIT_CW-1:0]   HIT_LAST   = HIT_CW'(HIT_N - 1);
    localparam logic [MISS_CW-1:0]  MISS_LAST  = MISS_CW'(MISS_N - 1);
    localparam logic [DWELL_CW-1:0] DWELL_LAST = DWELL_CW'(DWELL_N - 1);

    logic [W:0]          thr_ext;
    logic                hit;
    logic                locked_miss;

    acq_state_e          state_q, state_d;
    logic [HIT_CW-1:0]   hit_cnt_q, hit_cnt_d;
    logic [MISS_CW-1:0]  miss_cnt_q, miss_cnt_d;
    logic [DWELL_CW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic                dwell_to_d;
    logic                acq_q, acq_lock_q, dwell_to_q;

    acq_mag_est #(
        .W (W)
    ) u_mag (
        .clk_i     (mclk),
        .rst_i     (res),
        .vld_i     (aen),
        .a_i       (ain),
        .b_i       (bin),
        .mag_o     (integmag),
        .mag_vld_o (mag_vld)
    );

    // Detection test; in LOCKED the loss test is either the plain miss or the lower hysteresis threshold.
    always_comb begin
        thr_ext = (W+1)'(thresh);
        hit     = (integmag > thr_ext);
`ifdef ACQ_HYST_EN
        locked_miss = (integmag < (W+1)'(thresh_lo));
`else
        locked_miss = !hit;
`endif
    end

`ifndef ACQ_HYST_EN
    logic unused_thresh_lo;
    assign unused_thresh_lo = ^thresh_lo;
`endif

    // Next-state and counter logic; everything holds unless a new magnitude is valid.
    always_comb begin
        state_d     = state_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        dwell_to_d  = 1'b0;
        if (mag_vld) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hit) begin
                        dwell_cnt_d = '0;
                        if (HIT_N == 1) begin
                            state_d   = ST_LOCKED;
                            hit_cnt_d = '0;
                        end else begin
                            state_d   = ST_CONFIRM;
                            hit_cnt_d = HIT_CW'(1);
                        end
                    end else if (dwell_cnt_q == DWELL_LAST) begin
                        dwell_cnt_d = '0;
                        dwell_to_d  = 1'b1;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_CW'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (hit) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            state_d   = ST_LOCKED;
                            hit_cnt_d = '0;
                        end else begin
                            hit_cnt_d = hit_cnt_q + HIT_CW'(1);
                        end
                    end else begin
                        state_d   = ST_SEARCH;
                        hit_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (locked_miss) begin
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d     = ST_SEARCH;
                            hit_cnt_d   = '0;
                            miss_cnt_d  = '0;
                            dwell_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_CW'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_SEARCH;
                    hit_cnt_d   = '0;
                    miss_cnt_d  = '0;
                    dwell_cnt_d = '0;
                end
            endcase
        end
    end

    // FSM state, counters and registered flags; flags are decoded from the state being entered.
    always_ff @(posedge mclk) begin
        if (res) begin
            state_q     <= ST_SEARCH;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            acq_q       <= 1'b0;
            acq_lock_q  <= 1'b0;
            dwell_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            acq_q       <= (state_d == ST_CONFIRM) || (state_d == ST_LOCKED);
            acq_lock_q  <= (state_d == ST_LOCKED);
            dwell_to_q  <= dwell_to_d;
        end
    end

    assign acq      = acq_q;
    assign acq_lock = acq_lock_q;
    assign dwell_to = dwell_to_q;

endmodule

// File: tb/tb_acq_threshold_detector.sv
module tb_acq_threshold_detector;

    localparam int W  = 20;
    localparam int TW = 15;

    logic                mclk = 1'b0;
    logic                res;
    logic                aen;
    logic signed [W-1:0] ain;
    logic signed [W-1:0] bin;
    logic [TW-1:0]       thresh;
    logic [TW-1:0]       thresh_lo;
    logic [W:0]          integmag;
    logic                mag_vld;
    logic                acq;
    logic                acq_lock;
    logic                dwell_to;

    int checks = 0;
    int errors = 0;
    int dto_cnt = 0;
    int mv_cnt = 0;
    int base;

    acq_threshold_detector #(
        .W       (W),
        .TW      (TW),
        .HIT_N   (4),
        .MISS_N  (4),
        .DWELL_N (8)
    ) dut (
        .mclk      (mclk),
        .res       (res),
        .aen       (aen),
        .ain       (ain),
        .bin       (bin),
        .thresh    (thresh),
        .thresh_lo (thresh_lo),
        .integmag  (integmag),
        .mag_vld   (mag_vld),
        .acq       (acq),
        .acq_lock  (acq_lock),
        .dwell_to  (dwell_to)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (dwell_to) dto_cnt++;
        if (mag_vld)  mv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge mclk);
        res = 1'b1;
        aen = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        res = 1'b0;
    endtask

    // One isolated sample; returns at the negedge where its flags are visible (t+3).
    task automatic sample(input int a, input int b);
        @(negedge mclk);
        ain = W'(a);
        bin = W'(b);
        aen = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        aen = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
    endtask

    // n back-to-back samples; returns where the last sample's flags are visible.
    task automatic burst(input int n, input int a, input int b);
        @(negedge mclk);
        ain = W'(a);
        bin = W'(b);
        aen = 1'b1;
        repeat (n) @(posedge mclk);
        @(negedge mclk);
        aen = 1'b0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
    endtask

    initial begin
        res       = 1'b0;
        aen       = 1'b0;
        ain       = '0;
        bin       = '0;
        thresh    = 15'd1000;
        thresh_lo = 15'd800;

        // Reset state
        do_reset();
        chk("rst_integmag", 32'(integmag), 0);
        chk("rst_mag_vld",  32'(mag_vld),  0);
        chk("rst_acq",      32'(acq),      0);
        chk("rst_acq_lock", 32'(acq_lock), 0);
        chk("rst_dwell_to", 32'(dwell_to), 0);

        // Latency of one sample: 600/-800 -> 800 + 300 = 1100, a hit
        @(negedge mclk);
        ain = 20'sd600;
        bin = -20'sd800;
        aen = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        aen = 1'b0;
        chk("lat_t1_mag_vld", 32'(mag_vld), 0);
        @(posedge mclk);
        @(negedge mclk);
        chk("lat_t2_mag_vld",  32'(mag_vld),  1);
        chk("lat_t2_integmag", 32'(integmag), 1100);
        chk("lat_t2_acq",      32'(acq),      0);
        @(posedge mclk);
        @(negedge mclk);
        chk("lat_t3_acq",      32'(acq),      1);
        chk("lat_t3_acq_lock", 32'(acq_lock), 0);
        chk("lat_t3_mag_vld",  32'(mag_vld),  0);

        // Hits 2..4 -> lock after the 4th
        sample(600, -800);
        sample(600, -800);
        chk("hit3_acq_lock", 32'(acq_lock), 0);
        sample(600, -800);
        chk("hit4_acq_lock", 32'(acq_lock), 1);
        chk("hit4_acq",      32'(acq),      1);

        // Magnitude boundaries while locked
        sample(1000, 0);
        chk("mag_eq_thresh", 32'(integmag), 1000);
        chk("eq_miss_still_locked", 32'(acq_lock), 1);
        sample(1000, 1000);
        chk("mag_equal_inputs", 32'(integmag), 1500);
        sample(-524288, 0);
        chk("mag_most_negative", 32'(integmag), 524288);

        // Loss behaviour with magnitude 900 (thresh_lo = 800)
        sample(900, 0);
        sample(900, 0);
        sample(900, 0);
        chk("m900x3_lock", 32'(acq_lock), 1);
        sample(900, 0);
`ifdef ACQ_HYST_EN
        chk("m900x4_hyst_lock", 32'(acq_lock), 1);
        sample(700, 0);
        sample(700, 0);
        sample(700, 0);
        chk("m700x3_hyst_lock", 32'(acq_lock), 1);
        sample(700, 0);
        chk("m700x4_hyst_lock", 32'(acq_lock), 0);
        chk("m700x4_hyst_acq",  32'(acq),      0);
`else
        chk("m900x4_lock", 32'(acq_lock), 0);
        chk("m900x4_acq",  32'(acq),      0);
`endif

        // Three hits then a miss -> back to SEARCH; counting restarts
        do_reset();
        burst(3, 2000, 0);
        chk("c3_acq",      32'(acq),      1);
        chk("c3_acq_lock", 32'(acq_lock), 0);
        sample(0, 0);
        chk("cmiss_acq",      32'(acq),      0);
        chk("cmiss_acq_lock", 32'(acq_lock), 0);
        burst(3, 2000, 0);
        chk("rehit3_acq_lock", 32'(acq_lock), 0);
        chk("rehit3_acq",      32'(acq),      1);

        // Dwell timeout: 7 misses none, 8th pulses once, 16 total pulses twice
        do_reset();
        base = dto_cnt;
        burst(7, 0, 0);
        @(negedge mclk);
        chk("dwell7_pulses", 32'(dto_cnt - base), 0);
        burst(1, 0, 0);
        chk("dwell8_dwell_to", 32'(dwell_to), 1);
        @(negedge mclk);
        chk("dwell8_pulse_width", 32'(dwell_to), 0);
        chk("dwell8_pulses", 32'(dto_cnt - base), 1);
        burst(8, 0, 0);
        @(negedge mclk);
        chk("dwell16_pulses", 32'(dto_cnt - base), 2);
        chk("dwell16_acq", 32'(acq), 0);

        // Threshold change takes effect on the next magnitude without resetting the FSM
        thresh = 15'd500;
        sample(600, 0);
        chk("thr500_acq", 32'(acq), 1);
        thresh = 15'd1000;

        // Throughput: four back-to-back hits lock
        do_reset();
        burst(4, 2000, 0);
        chk("burst4_acq_lock", 32'(acq_lock), 1);

        // Reset while locked with samples in flight
        @(negedge mclk);
        ain = 20'sd2000;
        bin = 20'sd0;
        aen = 1'b1;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        res = 1'b1;
        @(posedge mclk);
        @(negedge mclk);
        chk("inflight_rst_integmag", 32'(integmag), 0);
        chk("inflight_rst_mag_vld",  32'(mag_vld),  0);
        chk("inflight_rst_acq",      32'(acq),      0);
        chk("inflight_rst_acq_lock", 32'(acq_lock), 0);
        chk("inflight_rst_dwell_to", 32'(dwell_to), 0);
        base = mv_cnt;
        res = 1'b0;
        aen = 1'b0;
        repeat (4) @(negedge mclk);
        chk("inflight_no_stale_vld", 32'(mv_cnt - base), 0);
        chk("inflight_post_acq",     32'(acq),           0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
